// File: rtl/div_sequencer.sv
// Multi-cycle radix-2 restoring divider with the EX-stage hold/flush sequencing around it.
// Optional build macro DIV_ZERO_FAST_EN: a zero divisor skips the iterative path and completes in one stall cycle.
module div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             startE,
    input  logic             signedE,
    input  logic [WIDTH-1:0] a_E,
    input  logic [WIDTH-1:0] b_E,
    input  logic             stallE_in,
    input  logic             flush,
    output logic             alu_stallE,
    output logic             div_readyE,
    output logic [WIDTH-1:0] hiE,
    output logic [WIDTH-1:0] loE
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] divisor_r;
    logic [WIDTH-1:0] dividendRaw_r;
    logic             signQ_r;
    logic             signR_r;
    logic             divZero_r;

    logic [WIDTH:0]   remShift_s;
    logic [WIDTH:0]   remSub_s;
    logic [WIDTH-1:0] remNext_s;
    logic [WIDTH-1:0] quoNext_s;
    logic [WIDTH-1:0] hiFinal_s;
    logic [WIDTH-1:0] loFinal_s;

    function automatic logic [WIDTH-1:0] condNeg(input logic [WIDTH-1:0] v, input logic en);
        condNeg = en ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    // Stall is released the moment the result is valid, and never raised for a killed instruction.
    assign alu_stallE = startE & ~flush & (state_r != DONE);

    // One restoring step plus the sign/zero-divisor fix applied to the final step's result.
    always_comb begin
        remShift_s = {rem_r, quo_r[WIDTH-1]};
        remSub_s   = remShift_s - {1'b0, divisor_r};
        remNext_s  = remShift_s[WIDTH-1:0];
        quoNext_s  = {quo_r[WIDTH-2:0], 1'b0};
        if (!remSub_s[WIDTH]) begin
            remNext_s = remSub_s[WIDTH-1:0];
            quoNext_s = {quo_r[WIDTH-2:0], 1'b1};
        end else begin
            remNext_s = remShift_s[WIDTH-1:0];
            quoNext_s = {quo_r[WIDTH-2:0], 1'b0};
        end
        if (divZero_r) begin
            hiFinal_s = dividendRaw_r;
            loFinal_s = ONES_W;
        end else begin
            hiFinal_s = condNeg(remNext_s, signR_r);
            loFinal_s = condNeg(quoNext_s, signQ_r);
        end
    end

    // Sequencer FSM and datapath registers; flush aborts from any state but leaves the last result visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            cnt_r         <= {CW{1'b0}};
            rem_r         <= ZERO_W;
            quo_r         <= ZERO_W;
            divisor_r     <= ZERO_W;
            dividendRaw_r <= ZERO_W;
            signQ_r       <= 1'b0;
            signR_r       <= 1'b0;
            divZero_r     <= 1'b0;
            hiE           <= ZERO_W;
            loE           <= ZERO_W;
            div_readyE    <= 1'b0;
        end else if (flush) begin
            state_r    <= IDLE;
            cnt_r      <= {CW{1'b0}};
            div_readyE <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (startE) begin
                        dividendRaw_r <= a_E;
                        quo_r         <= condNeg(a_E, signedE & a_E[WIDTH-1]);
                        divisor_r     <= condNeg(b_E, signedE & b_E[WIDTH-1]);
                        rem_r         <= ZERO_W;
                        cnt_r         <= {CW{1'b0}};
                        signQ_r       <= signedE & (a_E[WIDTH-1] ^ b_E[WIDTH-1]);
                        signR_r       <= signedE & a_E[WIDTH-1];
                        divZero_r     <= (b_E == ZERO_W);
`ifdef DIV_ZERO_FAST_EN
                        if (b_E == ZERO_W) begin
                            state_r    <= DONE;
                            hiE        <= a_E;
                            loE        <= ONES_W;
                            div_readyE <= 1'b1;
                        end else begin
                            state_r <= BUSY;
                        end
`else
                        state_r <= BUSY;
`endif
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    rem_r <= remNext_s;
                    quo_r <= quoNext_s;
                    cnt_r <= cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        state_r    <= DONE;
                        hiE        <= hiFinal_s;
                        loE        <= loFinal_s;
                        div_readyE <= 1'b1;
                    end else begin
                        state_r <= BUSY;
                    end
                end
                DONE: begin
                    // A held E stage still carries the same instruction, so startE must not relaunch it.
                    if (stallE_in) begin
                        state_r <= DONE;
                    end else begin
                        state_r    <= IDLE;
                        div_readyE <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    div_readyE <= 1'b0;
                end
            endcase
        end
    end

endmodule
